// File: rtl/stream_tx.sv
// Burst stream transmitter: one command yields cmd_len_i+1 beats on a valid/ready port.
// STREAM_TX_LFSR_EN selects the LFSR data pattern in place of the default incrementing one.
module stream_tx #(
  parameter int IDLE_GAP = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid_i,
  input  logic [7:0] cmd_len_i,
  input  logic [7:0] cmd_seed_i,
  output logic       cmd_ready_o,
  input  logic       e_ready_i,
  output logic       e_valid_o,
  output logic [7:0] e_data_o,
  output logic       e_last_o,
  output logic       done_o
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  localparam int          C_GL       = (IDLE_GAP > 0) ? IDLE_GAP - 1 : 0;
  localparam logic [3:0]  C_GAP_LAST = 4'(C_GL);

  state_t      r_state, w_next;
  logic [7:0]  r_len;
  logic [7:0]  r_data;
  logic [8:0]  r_cnt;
  logic [3:0]  r_gap;
  logic        r_done;

  logic        w_cmd_hs, w_beat_hs, w_last, w_last_hs, w_gap_end;
  logic [7:0]  w_seed;

  function automatic logic [7:0] f_succ(input logic [7:0] d);
`ifdef STREAM_TX_LFSR_EN
    return {d[6:0], d[7] ^ d[5] ^ d[4] ^ d[3]};
`else
    return d + 8'd1;
`endif
  endfunction

`ifdef STREAM_TX_LFSR_EN
  // All-zero is the LFSR lock-up state, so it is never loaded.
  assign w_seed = (cmd_seed_i == 8'h00) ? 8'h01 : cmd_seed_i;
`else
  assign w_seed = cmd_seed_i;
`endif

  assign w_cmd_hs  = cmd_valid_i && (r_state == S_IDLE);
  assign w_beat_hs = (r_state == S_SEND) && e_ready_i;
  assign w_last    = (r_state == S_SEND) && (r_cnt == {1'b0, r_len});
  assign w_last_hs = w_beat_hs && w_last;
  assign w_gap_end = (r_state == S_GAP) && (r_gap == C_GAP_LAST);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_cmd_hs)  w_next = S_SEND;
      S_SEND: if (w_last_hs) w_next = (IDLE_GAP > 0) ? S_GAP : S_IDLE;
      S_GAP:  if (w_gap_end) w_next = S_IDLE;
      default:               w_next = S_IDLE;
    endcase
  end

  // Data and count advance only on a non-final handshake, so a stalled beat repeats.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_len  <= 8'h00;
      r_data <= 8'h00;
      r_cnt  <= 9'd0;
      r_gap  <= 4'd0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_last_hs;
      if (w_cmd_hs) begin
        r_len  <= cmd_len_i;
        r_data <= w_seed;
        r_cnt  <= 9'd0;
      end else if (w_beat_hs && !w_last) begin
        r_cnt  <= r_cnt + 9'd1;
        r_data <= f_succ(r_data);
      end
      if (w_last_hs)               r_gap <= 4'd0;
      else if (r_state == S_GAP)   r_gap <= r_gap + 4'd1;
    end
  end

  assign cmd_ready_o = (r_state == S_IDLE);
  assign e_valid_o   = (r_state == S_SEND);
  assign e_data_o    = r_data;
  assign e_last_o    = w_last;
  assign done_o      = r_done;

endmodule

// File: doc/stream_tx.md
STREAM_TX -- requirements
Module: stream_tx

Interface
REQ-001 SHALL provide parameter IDLE_GAP, default 0, meaning idle cycles forced after each burst before the next command is accepted (0..15).
REQ-002 SHALL provide clk  input  1  clock; all logic on rising edge.
REQ-003 SHALL provide reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL provide cmd_valid_i  input  1  burst command valid.
REQ-005 SHALL provide cmd_len_i  input  8  burst length minus one (beats = cmd_len_i+1, range 1..256).
REQ-006 SHALL provide cmd_seed_i  input  8  first data value of the burst.
REQ-007 SHALL provide cmd_ready_o  output  1  command accepted when cmd_valid_i && cmd_ready_o.
REQ-008 SHALL provide e_ready_i  input  1  downstream ready.
REQ-009 SHALL provide e_valid_o  output  1  beat valid.
REQ-010 SHALL provide e_data_o  output  8  beat data.
REQ-011 SHALL provide e_last_o  output  1  marks final beat of burst.
REQ-012 SHALL provide done_o  output  1  one-cycle pulse after final beat handshake.

Function
REQ-013 SHALL implement FSM states IDLE, SEND, GAP; cmd_ready_o = 1 only in IDLE.
REQ-014 IDLE -> SEND on command handshake; length and seed captured that edge; e_valid_o = 1 the following cycle (1-cycle latency).
REQ-015 SEND: e_valid_o = 1 continuously; beat transfers when e_valid_o && e_ready_i.
REQ-016 While e_valid_o && !e_ready_i, e_data_o and e_last_o SHALL hold stable; e_valid_o SHALL never drop without a handshake.
REQ-017 SHALL count beats with a 9-bit counter; e_last_o = 1 exactly when counter equals cmd_len_i captured value.
REQ-018 On last-beat handshake: SEND -> GAP if IDLE_GAP > 0, else SEND -> IDLE; done_o = 1 the next cycle only.
REQ-019 GAP: count IDLE_GAP cycles with e_valid_o = 0, cmd_ready_o = 0, then -> IDLE.
REQ-020 Back-to-back: with IDLE_GAP = 0 a command accepted in the cycle after last beat SHALL start a burst with one idle bubble between bursts (no overlap).
REQ-021 Beat 0 data = seed; default successor = previous + 1 mod 256 (wraps 8'hFF -> 8'h00).
REQ-022 Data SHALL advance only on handshake; a stalled beat repeats its value.
REQ-023 cmd_len_i = 8'hFF SHALL produce 256 beats, counter not overflowing.
REQ-024 cmd_valid_i while not IDLE SHALL be ignored (no capture, no side effect).
REQ-025 e_ready_i while e_valid_o = 0 SHALL have no effect.

Reset
REQ-026 While reset sampled high: state IDLE, counters 0, e_valid_o 0, e_data_o 8'h00, e_last_o 0, done_o 0; cmd_ready_o 1 from the first cycle after reset deasserts.
REQ-027 Reset mid-burst SHALL abort the burst; no done_o pulse; remaining beats discarded.

Configuration
REQ-028 Macro STREAM_TX_LFSR_EN SHALL select the data pattern.
REQ-029 Without STREAM_TX_LFSR_EN: incrementing pattern per REQ-021.
REQ-030 With STREAM_TX_LFSR_EN: successor = {d[6:0], d[7]^d[5]^d[4]^d[3]}; seed 8'h00 SHALL be replaced by 8'h01 for beat 0 and onward.
REQ-031 All handshake, timing and reset behaviour SHALL be identical in both builds.

Verification
REQ-032 Basic: len=3, seed=8'h10, e_ready_i=1 -> beats 10,11,12,13; e_last_o on 13; done_o one cycle after; 4 consecutive valid cycles.
REQ-033 Backpressure: len=2, seed=8'hFE, e_ready_i low cycles 2-4 of burst -> data held stable while stalled; sequence FE,FF,00; no valid drop.
REQ-034 Max length: len=8'hFF, seed=0 -> 256 beats, last data 8'hFF, e_last_o only on beat 256.
REQ-035 Gap: IDLE_GAP=3, two commands back-to-back -> cmd_ready_o low for exactly 3 cycles after done window; second burst starts after.
REQ-036 Reset mid-burst: reset at beat 2 of len=7 -> next cycle e_valid_o=0, cmd_ready_o=1 after release, no done_o.
REQ-037 LFSR build: seed=8'h00, len=2 -> beats 01,02,04.
